// File: rtl/nit_loader_pkg.sv
// Shared types, default parameters and the partial-word padding helper
// for the nit word loader.
package nit_loader_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } nit_state_e;

    localparam int unsigned NIT_WIDTH_DEF     = 2;
    localparam int unsigned NITS_PER_WORD_DEF = 6;
    localparam int unsigned ADDR_WIDTH_DEF    = 8;
    localparam bit          MSB_FIRST_DEF     = 1'b1;

    // Widest word the padding helper handles; callers truncate the result.
    localparam int unsigned PAD_MAX_W = 256;

    // Align a partial accumulator as if the missing trailing nits were zero.
    function automatic logic [PAD_MAX_W-1:0] pad_partial(
        input logic [PAD_MAX_W-1:0] acc,
        input int unsigned          nit_cnt,
        input int unsigned          nit_width,
        input int unsigned          nits_per_word,
        input bit                   msb_first
    );
        int unsigned sh;
        sh = (nits_per_word - nit_cnt) * nit_width;
        if (msb_first) begin
            return acc << sh;
        end
        return acc >> sh;
    endfunction

endpackage

// File: rtl/nit_ram.sv
// Simple dual-port program RAM: one write port, one registered read port
// returning old data on a same-address collision.
module nit_ram #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; only the output register is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/nit_word_loader.sv
// Packs a stream of color nits into program words and writes them into the
// program RAM, with flush, fill count, full/overflow flags and clear.
module nit_word_loader
    import nit_loader_pkg::*;
#(
    parameter int unsigned NIT_WIDTH     = NIT_WIDTH_DEF,
    parameter int unsigned NITS_PER_WORD = NITS_PER_WORD_DEF,
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter bit          MSB_FIRST     = MSB_FIRST_DEF,
    localparam int unsigned DATA_WIDTH   = NIT_WIDTH * NITS_PER_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nit_valid,
    input  logic [NIT_WIDTH-1:0]  nit,
    input  logic                  finish,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  full,
    output logic                  overflow,
    output logic                  done
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned NCNT_W = $clog2(NITS_PER_WORD + 1);

    localparam logic [CNT_W-1:0]  DEPTH    = CNT_W'(1) << ADDR_WIDTH;
    localparam logic [NCNT_W-1:0] LAST_NIT = NCNT_W'(NITS_PER_WORD - 1);

    localparam logic [1:0] ST_FILL  = FILL;
    localparam logic [1:0] ST_FLUSH = FLUSH;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] acc_q,      acc_d;
    logic [NCNT_W-1:0]     nit_cnt_q,  nit_cnt_d;
    logic [CNT_W-1:0]      wc_q,       wc_d;
    logic                  full_q,     full_d;
    logic                  ovf_q,      ovf_d;
    logic                  done_q,     done_d;
    logic                  wr_pend_q,  wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;

    logic [DATA_WIDTH-1:0] acc_shift;
    logic [DATA_WIDTH-1:0] pad_word;
    logic [CNT_W-1:0]      issued;
    logic                  cap_full;
    logic                  ram_we;

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        nit_cnt_d = nit_cnt_q;
        wc_d      = wc_q;
        ovf_d     = ovf_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (MSB_FIRST) begin
            acc_shift = DATA_WIDTH'({acc_q, nit});
        end else begin
            acc_shift = DATA_WIDTH'({nit, acc_q} >> NIT_WIDTH);
        end
        pad_word = DATA_WIDTH'(pad_partial(PAD_MAX_W'(acc_q), 32'(nit_cnt_q),
                                           NIT_WIDTH, NITS_PER_WORD, MSB_FIRST));

        // Capacity counts the word still in flight so no address is reused.
        issued   = wc_q + CNT_W'(wr_pend_q);
        cap_full = (issued == DEPTH);

        if (wr_pend_q) begin
            wc_d = wc_q + CNT_W'(1);
        end

        case (state_q)
            ST_FILL: begin
                if (nit_valid) begin
                    if (cap_full) begin
                        ovf_d = 1'b1;
                    end else if (nit_cnt_q == LAST_NIT) begin
                        wr_pend_d = 1'b1;
                        wr_addr_d = ADDR_WIDTH'(issued);
                        wr_data_d = acc_shift;
                        acc_d     = '0;
                        nit_cnt_d = '0;
                    end else begin
                        acc_d     = acc_shift;
                        nit_cnt_d = nit_cnt_q + NCNT_W'(1);
                    end
                end
                if (finish) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((nit_cnt_q != '0) && !cap_full) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(issued);
                    wr_data_d = pad_word;
                end
                acc_d     = '0;
                nit_cnt_d = '0;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (clear) begin
            state_d   = ST_FILL;
            acc_d     = '0;
            nit_cnt_d = '0;
            wc_d      = '0;
            ovf_d     = 1'b0;
            wr_pend_d = 1'b0;
        end

        done_d = (state_d == ST_DONE);
        full_d = clear ? 1'b0 : (wc_q == DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FILL;
            acc_q     <= '0;
            nit_cnt_q <= '0;
            wc_q      <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            nit_cnt_q <= nit_cnt_d;
            wc_q      <= wc_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // A pending write is dropped if clear or reset lands on its edge.
    assign ram_we = wr_pend_q && !clear && !reset;

    nit_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_we),
        .wr_addr (wr_addr_q),
        .wr_data (wr_data_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign word_count = wc_q;
    assign full       = full_q;
    assign overflow   = ovf_q;
    assign done       = done_q;

endmodule

// File: tb/tb_nit_word_loader.sv
// Bench for nit_word_loader: three configurations driven in lockstep and
// checked against a word-level reference model.
module tb_nit_word_loader;

    localparam int NPW = 6;
    localparam int NW  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       nit_valid;
    logic [1:0] nit;
    logic       finish;
    logic       clear;
    logic [7:0] rd_addr;

    logic [11:0] rd_data_a, rd_data_b, rd_data_c;
    logic [8:0]  wc_a, wc_b;
    logic [2:0]  wc_c;
    logic        full_a, full_b, full_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        done_a, done_b, done_c;

    logic [11:0] rd_o [3];
    logic [8:0]  wc_o [3];
    logic [2:0]  full_v, ovf_v, done_v;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per configuration.
    int m_part [3][NPW];
    int m_np   [3];
    int m_wc   [3];
    bit m_ovf  [3];
    int m_st   [3];
    int m_mem  [3][256];
    bit m_pv   [3];
    int m_pa   [3];
    int m_pw   [3];

    nit_word_loader dut_a (
        .clk(clk), .reset(reset), .nit_valid(nit_valid), .nit(nit), .finish(finish),
        .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data_a), .word_count(wc_a),
        .full(full_a), .overflow(ovf_a), .done(done_a));

    nit_word_loader #(.MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .nit_valid(nit_valid), .nit(nit), .finish(finish),
        .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data_b), .word_count(wc_b),
        .full(full_b), .overflow(ovf_b), .done(done_b));

    nit_word_loader #(.ADDR_WIDTH(2)) dut_c (
        .clk(clk), .reset(reset), .nit_valid(nit_valid), .nit(nit), .finish(finish),
        .clear(clear), .rd_addr(rd_addr[1:0]), .rd_data(rd_data_c), .word_count(wc_c),
        .full(full_c), .overflow(ovf_c), .done(done_c));

    assign rd_o[0] = rd_data_a;
    assign rd_o[1] = rd_data_b;
    assign rd_o[2] = rd_data_c;
    assign wc_o[0] = wc_a;
    assign wc_o[1] = wc_b;
    assign wc_o[2] = {6'd0, wc_c};
    assign full_v  = {full_c, full_b, full_a};
    assign ovf_v   = {ovf_c, ovf_b, ovf_a};
    assign done_v  = {done_c, done_b, done_a};

    always #5 clk = ~clk;

    function automatic int depth_of(input int d);
        return (d == 2) ? 4 : 256;
    endfunction

    // Word value from its nits: nit i sits at slot i from the chosen end.
    function automatic int pack_word(input int d, input int n);
        int w = 0;
        for (int i = 0; i < n; i++) begin
            w |= m_part[d][i] << ((d == 1) ? i * NW : (NPW - 1 - i) * NW);
        end
        return w;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_np[d] = 0; m_wc[d] = 0; m_ovf[d] = 1'b0; m_st[d] = 0; m_pv[d] = 1'b0;
        end
    endfunction

    // One clock of behaviour: states 0=FILL, 1=FLUSH, 2=DONE.
    function automatic void model_step(input int d, input bit v, input int n,
                                       input bit f, input bit c);
        if (m_pv[d]) begin
            if (!c) m_mem[d][m_pa[d]] = m_pw[d];
            m_pv[d] = 1'b0;
        end
        if (c) begin
            m_np[d] = 0; m_wc[d] = 0; m_ovf[d] = 1'b0; m_st[d] = 0;
            return;
        end
        if (m_st[d] == 0) begin
            if (v) begin
                if (m_wc[d] == depth_of(d)) begin
                    m_ovf[d] = 1'b1;
                end else begin
                    m_part[d][m_np[d]] = n;
                    m_np[d]++;
                    if (m_np[d] == NPW) begin
                        m_pv[d] = 1'b1; m_pa[d] = m_wc[d]; m_pw[d] = pack_word(d, NPW);
                        m_wc[d]++; m_np[d] = 0;
                    end
                end
            end
            if (f) m_st[d] = 1;
        end else if (m_st[d] == 1) begin
            if (m_np[d] != 0 && m_wc[d] < depth_of(d)) begin
                m_pv[d] = 1'b1; m_pa[d] = m_wc[d]; m_pw[d] = pack_word(d, m_np[d]);
                m_wc[d]++;
            end
            m_np[d] = 0;
            m_st[d] = 2;
        end
    endfunction

    task automatic step(input bit v, input int n, input bit f, input bit c);
        nit_valid = v; nit = 2'(n); finish = f; clear = c;
        for (int d = 0; d < 3; d++) model_step(d, v, n, f, c);
        @(posedge clk); #1;
        nit_valid = 1'b0; nit = 2'd0; finish = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; nit_valid = 1'b0; nit = 2'd0; finish = 1'b0; clear = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({wc_o[d], full_v[d], ovf_v[d], done_v[d]} !== 12'd0) begin
                errors++;
                $display("FAIL reset_flags dut%0d got wc=%0d full=%b ovf=%b done=%b exp all 0",
                         d, wc_o[d], full_v[d], ovf_v[d], done_v[d]);
            end
            checks++;
            if (rd_o[d] !== 12'h000) begin
                errors++;
                $display("FAIL reset_rd_data dut%0d got %h exp 000", d, rd_o[d]);
            end
        end
    endtask

    task automatic test_basic_word();
        int nits [NPW] = '{1, 2, 3, 0, 1, 2};
        do_reset(1);
        rd_addr = 8'd0;
        for (int i = 0; i < NPW; i++) step(1'b1, nits[i], 1'b0, 1'b0);
        checks++;
        if (wc_a !== 9'd0) begin
            errors++; $display("FAIL basic_wc_before_write got %0d exp 0", wc_a);
        end
        step(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (wc_a !== 9'd1) begin
            errors++; $display("FAIL basic_wc_after_write got %0d exp 1", wc_a);
        end
        step(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (rd_data_a !== 12'h6C6) begin
            errors++; $display("FAIL basic_word_msb got %h exp 6c6", rd_data_a);
        end
        for (int d = 1; d < 3; d++) begin
            checks++;
            if (rd_o[d] !== 12'(m_mem[d][0])) begin
                errors++; $display("FAIL basic_word dut%0d got %h exp %h", d, rd_o[d], 12'(m_mem[d][0]));
            end
        end
    endtask

    task automatic test_flush_partial();
        do_reset(1);
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (done_v !== 3'b000) begin
            errors++; $display("FAIL flush_done_early got %b exp 000", done_v);
        end
        step(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (done_v !== 3'b111) begin
            errors++; $display("FAIL flush_done got %b exp 111", done_v);
        end
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        rd_addr = 8'd0;
        step(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({rd_data_a, wc_a, ovf_a} !== {12'hF00, 9'd1, 1'b0}) begin
            errors++;
            $display("FAIL flush_word got word=%h wc=%0d ovf=%b exp word=f00 wc=1 ovf=0",
                     rd_data_a, wc_a, ovf_a);
        end
        checks++;
        if (rd_data_b !== 12'(m_mem[1][0])) begin
            errors++; $display("FAIL flush_word_lsb got %h exp %h", rd_data_b, 12'(m_mem[1][0]));
        end
    endtask

    task automatic test_finish_with_nit();
        int ks [2] = '{4, 6};
        for (int t = 0; t < 2; t++) begin
            do_reset(1);
            for (int i = 0; i < ks[t] - 1; i++) step(1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
            step(1'b1, $urandom_range(0, 3), 1'b1, 1'b0);
            repeat (3) step(1'b0, 0, 1'b0, 1'b0);
            rd_addr = 8'd0;
            step(1'b0, 0, 1'b0, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({wc_o[d], done_v[d], rd_o[d]} !== {9'(m_wc[d]), 1'b1, 12'(m_mem[d][0])}) begin
                    errors++;
                    $display("FAIL finish_with_nit k=%0d dut%0d got wc=%0d done=%b word=%h exp wc=%0d done=1 word=%h",
                             ks[t], d, wc_o[d], done_v[d], rd_o[d], m_wc[d], 12'(m_mem[d][0]));
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset(1);
        for (int i = 0; i < 24; i++) step(1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
        checks++;
        if (ovf_c !== 1'b0) begin
            errors++; $display("FAIL ovf_before_25 got %b exp 0", ovf_c);
        end
        step(1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
        checks++;
        if ({ovf_c, wc_c, full_c} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL ovf_after_25 got ovf=%b wc=%0d full=%b exp ovf=1 wc=4 full=0", ovf_c, wc_c, full_c);
        end
        step(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (full_c !== 1'b1) begin
            errors++; $display("FAIL full_asserts got %b exp 1", full_c);
        end
        repeat (3) step(1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({wc_o[d], full_v[d], ovf_v[d]} !== {9'(m_wc[d]), m_wc[d] == depth_of(d), m_ovf[d]}) begin
                errors++;
                $display("FAIL ovf_state dut%0d got wc=%0d full=%b ovf=%b exp wc=%0d ovf=%b",
                         d, wc_o[d], full_v[d], ovf_v[d], m_wc[d], m_ovf[d]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 8'(i);
            step(1'b0, 0, 1'b0, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (rd_o[d] !== 12'(m_mem[d][i])) begin
                    errors++; $display("FAIL ovf_word dut%0d addr %0d got %h exp %h", d, i, rd_o[d], 12'(m_mem[d][i]));
                end
            end
        end
    endtask

    task automatic test_clear();
        int x_nits [NPW] = '{1, 2, 3, 0, 1, 2};
        int z_nits [NPW] = '{2, 1, 0, 3, 2, 1};
        int old_w [3];
        do_reset(1);
        for (int i = 0; i < NPW; i++) step(1'b1, x_nits[i], 1'b0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (wc_a !== 9'd0) begin
            errors++; $display("FAIL clear_wc got %0d exp 0", wc_a);
        end
        // clear together with the sixth nit
        for (int i = 0; i < 5; i++) step(1'b1, 3, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b1);
        repeat (2) step(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({wc_a, wc_b, wc_c} !== 21'd0) begin
            errors++; $display("FAIL clear_sixth_nit got wc=%0d/%0d/%0d exp 0", wc_a, wc_b, wc_c);
        end
        // clear on the edge of a pending write
        for (int i = 0; i < NPW; i++) step(1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0);
        rd_addr = 8'd0;
        step(1'b0, 0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({wc_o[d], rd_o[d]} !== {9'd0, 12'(m_mem[d][0])}) begin
                errors++;
                $display("FAIL clear_pending dut%0d got wc=%0d word=%h exp wc=0 word=%h",
                         d, wc_o[d], rd_o[d], 12'(m_mem[d][0]));
            end
            old_w[d] = m_mem[d][0];
        end
        // same-address read during write returns old data
        for (int i = 0; i < NPW; i++) step(1'b1, z_nits[i], 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({wc_o[d], rd_o[d]} !== {9'd1, 12'(old_w[d])}) begin
                errors++;
                $display("FAIL collision_old dut%0d got wc=%0d word=%h exp wc=1 word=%h",
                         d, wc_o[d], rd_o[d], 12'(old_w[d]));
            end
        end
        step(1'b0, 0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rd_o[d] !== 12'(m_mem[d][0])) begin
                errors++; $display("FAIL collision_new dut%0d got %h exp %h", d, rd_o[d], 12'(m_mem[d][0]));
            end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b0, 1'b0);
        do_reset(1);
        for (int i = 0; i < NPW; i++) step(1'b1, $urandom_range(0, 3), 1'b0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0, 1'b0);
        rd_addr = 8'd0;
        step(1'b0, 0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({wc_o[d], rd_o[d]} !== {9'd1, 12'(pack_word(d, NPW))}) begin
                errors++;
                $display("FAIL reset_mid_word dut%0d got wc=%0d word=%h exp wc=1 word=%h",
                         d, wc_o[d], rd_o[d], 12'(pack_word(d, NPW)));
            end
        end
    endtask

    task automatic test_random();
        int len;
        bit v, f, c;
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) do_reset(1);
            else step(1'b0, 0, 1'b0, 1'b1);
            len = $urandom_range(20, 160);
            for (int i = 0; i < len; i++) begin
                v = ($urandom_range(0, 9) < 7) && (m_st[0] != 1);
                f = (m_st[0] == 0) && ($urandom_range(0, 49) == 0);
                c = ($urandom_range(0, 79) == 0);
                step(v, $urandom_range(0, 3), f, c);
            end
            if (r >= 3) step(1'b0, 0, 1'b1, 1'b0);
            repeat (3) step(1'b0, 0, 1'b0, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if ({wc_o[d], full_v[d], ovf_v[d], done_v[d]} !==
                    {9'(m_wc[d]), m_wc[d] == depth_of(d), m_ovf[d], m_st[d] == 2}) begin
                    errors++;
                    $display("FAIL random_state r=%0d dut%0d got wc=%0d full=%b ovf=%b done=%b exp wc=%0d ovf=%b st=%0d",
                             r, d, wc_o[d], full_v[d], ovf_v[d], done_v[d], m_wc[d], m_ovf[d], m_st[d]);
                end
            end
            for (int i = 0; i < m_wc[0] || i < m_wc[1]; i++) begin
                rd_addr = 8'(i);
                step(1'b0, 0, 1'b0, 1'b0);
                for (int d = 0; d < 3; d++) begin
                    if (i < m_wc[d]) begin
                        checks++;
                        if (rd_o[d] !== 12'(m_mem[d][i])) begin
                            errors++;
                            $display("FAIL random_word r=%0d dut%0d addr %0d got %h exp %h",
                                     r, d, i, rd_o[d], 12'(m_mem[d][i]));
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1; nit_valid = 1'b0; nit = 2'd0; finish = 1'b0; clear = 1'b0; rd_addr = 8'd0;
        test_reset();
        test_basic_word();
        test_flush_partial();
        test_finish_with_nit();
        test_overflow();
        test_clear();
        test_reset_mid_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
